// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IRD  = 2'd1,
    GNT_DRD  = 2'd2,
    GNT_DWR  = 2'd3
  } gnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the I-refill, D-refill and D-write-back requesters.
// DWR beats DRD inside the D class; last_d = 1 hands an I/D tie to the I class.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic irom_read_ce,
  input  logic dram_read_ce,
  input  logic dram_write_ce,
  input  logic last_d,
  output gnt_t gnt
);

  logic d_req;
  gnt_t d_gnt;

  assign d_req = dram_write_ce | dram_read_ce;
  assign d_gnt = dram_write_ce ? GNT_DWR : GNT_DRD;

  // Class-level choice, then in-class priority.
  always_comb begin
    gnt = GNT_NONE;
    if (d_req && irom_read_ce && last_d)
      gnt = GNT_IRD;
    else if (d_req)
      gnt = d_gnt;
    else if (irom_read_ce)
      gnt = GNT_IRD;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester external memory arbiter (I-refill, D-refill, D-write-back).
// MEM_ARB_RR_EN: round-robin between the I and D classes instead of fixed DWR > DRD > IRD.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              irom_read_ce,
  input  logic [ADDR_W-1:0] irom_addr,
  output logic              irom_fin,
  output logic [DATA_W-1:0] rom_inst,
  input  logic              dram_read_ce,
  input  logic [ADDR_W-1:0] dram_read_addr,
  output logic              dram_read_fin,
  output logic [DATA_W-1:0] ram_rdata,
  input  logic              dram_write_ce,
  input  logic [ADDR_W-1:0] dram_write_addr,
  input  logic [DATA_W-1:0] dram_cache_wb_data,
  output logic              dram_write_fin,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              arb_busy
);

  state_t state;
  gnt_t   gnt;
  gnt_t   pick;
  logic   last_d;

  mem_arb_pick u_pick (
    .irom_read_ce  (irom_read_ce),
    .dram_read_ce  (dram_read_ce),
    .dram_write_ce (dram_write_ce),
    .last_d        (last_d),
    .gnt           (pick)
  );

`ifdef MEM_ARB_RR_EN
  // Remember which class won the most recent grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_d <= 1'b0;
    else if (state == ST_IDLE && pick != GNT_NONE)
      last_d <= (pick != GNT_IRD);
  end
`else
  // Tied to the I class, the picker degenerates to fixed DWR > DRD > IRD.
  assign last_d = 1'b0;
`endif

  assign arb_busy = (state != ST_IDLE);

  // Grant, bus transfer and completion handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      gnt            <= GNT_NONE;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      irom_fin       <= 1'b0;
      dram_read_fin  <= 1'b0;
      dram_write_fin <= 1'b0;
      rom_inst       <= '0;
      ram_rdata      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick != GNT_NONE) begin
            gnt     <= pick;
            state   <= ST_BUSY;
            bus_req <= 1'b1;
            bus_we  <= (pick == GNT_DWR);
            case (pick)
              GNT_DWR: begin
                bus_addr  <= dram_write_addr;
                bus_wdata <= dram_cache_wb_data;
              end
              GNT_DRD: bus_addr <= dram_read_addr;
              GNT_IRD: bus_addr <= irom_addr;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= ST_RESP;
            case (gnt)
              GNT_IRD: begin
                rom_inst <= bus_rdata;
                irom_fin <= 1'b1;
              end
              GNT_DRD: begin
                ram_rdata     <= bus_rdata;
                dram_read_fin <= 1'b1;
              end
              GNT_DWR: dram_write_fin <= 1'b1;
              default: ;
            endcase
          end
        end
        ST_RESP: begin
          irom_fin       <= 1'b0;
          dram_read_fin  <= 1'b0;
          dram_write_fin <= 1'b0;
          gnt            <= GNT_NONE;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
// Honours MEM_ARB_RR_EN to select round-robin expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        irom_read_ce = 1'b0;
  logic [29:0] irom_addr = '0;
  logic        irom_fin;
  logic [31:0] rom_inst;
  logic        dram_read_ce = 1'b0;
  logic [29:0] dram_read_addr = '0;
  logic        dram_read_fin;
  logic [31:0] ram_rdata;
  logic        dram_write_ce = 1'b0;
  logic [29:0] dram_write_addr = '0;
  logic [31:0] dram_cache_wb_data = '0;
  logic        dram_write_fin;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'hFFFF_FFFF;
  logic        bus_ack = 1'b0;
  logic        arb_busy;

  int passed = 0;
  int total  = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .irom_read_ce       (irom_read_ce),
    .irom_addr          (irom_addr),
    .irom_fin           (irom_fin),
    .rom_inst           (rom_inst),
    .dram_read_ce       (dram_read_ce),
    .dram_read_addr     (dram_read_addr),
    .dram_read_fin      (dram_read_fin),
    .ram_rdata          (ram_rdata),
    .dram_write_ce      (dram_write_ce),
    .dram_write_addr    (dram_write_addr),
    .dram_cache_wb_data (dram_cache_wb_data),
    .dram_write_fin     (dram_write_fin),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_rdata          (bus_rdata),
    .bus_ack            (bus_ack),
    .arb_busy           (arb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // Reference model. Requester kinds: 1 = I-refill, 2 = D-refill, 3 = D-write-back.
  // Phase: 0 waiting for requests, 1 transfer on the bus, 2 reporting completion.
  int          m_phase;
  int          m_kind;
  bit          m_last_d;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rom;
  logic [31:0] m_ram;
  logic [2:0]  m_fin;   // {write, read, irom}

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase  <= 0;
      m_kind   <= 0;
      m_last_d <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_rom    <= '0;
      m_ram    <= '0;
      m_fin    <= '0;
    end else if (m_phase == 2) begin
      m_fin   <= '0;
      m_phase <= 0;
    end else if (m_phase == 1) begin
      if (bus_ack) begin
        if (m_kind == 1) m_rom <= bus_rdata;
        if (m_kind == 2) m_ram <= bus_rdata;
        m_fin   <= 3'b001 << (m_kind - 1);
        m_phase <= 2;
      end
    end else begin : choose
      int d_kind;
      int w;
      d_kind = dram_write_ce ? 3 : (dram_read_ce ? 2 : 0);
      if (d_kind != 0 && irom_read_ce) w = (RR && m_last_d) ? 1 : d_kind;
      else if (d_kind != 0)            w = d_kind;
      else if (irom_read_ce)           w = 1;
      else                             w = 0;
      if (w != 0) begin
        m_kind   <= w;
        m_phase  <= 1;
        m_last_d <= (w != 1);
        m_addr   <= (w == 3) ? dram_write_addr : (w == 2) ? dram_read_addr : irom_addr;
        if (w == 3) m_wdata <= dram_cache_wb_data;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("bus_req", {31'b0, bus_req}, {31'b0, m_phase == 1});
    chk("arb_busy", {31'b0, arb_busy}, {31'b0, m_phase != 0});
    chk("fins", {29'b0, dram_write_fin, dram_read_fin, irom_fin}, {29'b0, m_fin});
    chk("rom_inst", rom_inst, m_rom);
    chk("ram_rdata", ram_rdata, m_ram);
    if (m_phase == 1) begin
      chk("bus_we", {31'b0, bus_we}, {31'b0, m_kind == 3});
      chk("bus_addr", {2'b0, bus_addr}, {2'b0, m_addr});
      if (m_kind == 3) chk("bus_wdata", bus_wdata, m_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (bus_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus_req !== 1'b1) begin
      total++;
      $display("FAIL wait_req: bus_req not seen within %0d cycles, got %b expected 1", n, bus_req);
    end
  endtask

  // Called in BUSY cycle 1; acks in BUSY cycle n and returns in the completion cycle.
  task automatic ack_after(input int n, input logic [31:0] d);
    for (int i = 1; i < n; i++) tick();
    bus_ack   = 1'b1;
    bus_rdata = d;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'hFFFF_FFFF;
  endtask

  // Requester side: drop the ce of whichever fin is up and report its kind.
  task automatic finish_fin(output int kind);
    int cnt;
    kind = 0;
    cnt  = 0;
    if (irom_fin === 1'b1)       begin kind = 1; cnt++; irom_read_ce  = 1'b0; end
    if (dram_read_fin === 1'b1)  begin kind = 2; cnt++; dram_read_ce  = 1'b0; end
    if (dram_write_fin === 1'b1) begin kind = 3; cnt++; dram_write_ce = 1'b0; end
    chk("fin_count", cnt, 1);
  endtask

  int grants[4];
  int exp_seq[4];

  initial begin
    int k;
    int d_left;
    int i_left;

    // Reset state
    tick();
    tick();
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_busy", {31'b0, arb_busy}, 32'd0);
    chk("rst_rom", rom_inst, 32'd0);
    rst = 1'b1;
    tick();

    // Lone I-refill
    irom_read_ce = 1'b1;
    irom_addr    = 30'h0000100;
    wait_req();
    chk("ird_we", {31'b0, bus_we}, 32'd0);
    chk("ird_addr", {2'b0, bus_addr}, 32'h0000100);
    ack_after(2, 32'h3C010001);
    chk("ird_fin", {31'b0, irom_fin}, 32'd1);
    chk("ird_data", rom_inst, 32'h3C010001);
    finish_fin(k);
    chk("ird_kind", k, 1);
    tick();
    chk("ird_fin_pulse", {31'b0, irom_fin}, 32'd0);

    // Simultaneous write-back and refill, write address changed mid-transfer
    dram_read_ce       = 1'b1;
    dram_read_addr     = 30'h200;
    dram_write_ce      = 1'b1;
    dram_write_addr    = 30'h40;
    dram_cache_wb_data = 32'hDEADBEEF;
    wait_req();
    chk("dwr_we", {31'b0, bus_we}, 32'd1);
    chk("dwr_addr", {2'b0, bus_addr}, 32'h40);
    chk("dwr_wdata", bus_wdata, 32'hDEADBEEF);
    dram_write_addr    = 30'h55;
    dram_cache_wb_data = 32'h0BAD0BAD;
    tick();
    chk("dwr_addr_hold", {2'b0, bus_addr}, 32'h40);
    chk("dwr_wdata_hold", bus_wdata, 32'hDEADBEEF);
    ack_after(2, 32'h12345678);
    finish_fin(k);
    chk("dwr_kind", k, 3);
    wait_req();
    chk("drd_we", {31'b0, bus_we}, 32'd0);
    chk("drd_addr", {2'b0, bus_addr}, 32'h200);
    ack_after(1, 32'hCAFEF00D);
    chk("drd_data", ram_rdata, 32'hCAFEF00D);
    chk("drd_rom_kept", rom_inst, 32'h3C010001);
    finish_fin(k);
    chk("drd_kind", k, 2);
    tick();

    // Spurious ack while idle
    bus_ack   = 1'b1;
    bus_rdata = 32'h11111111;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'hFFFF_FFFF;
    chk("spur_fins", {29'b0, dram_write_fin, dram_read_fin, irom_fin}, 32'd0);
    chk("spur_busy", {31'b0, arb_busy}, 32'd0);
    tick();
    chk("spur_busy2", {31'b0, arb_busy}, 32'd0);
    chk("spur_ram", ram_rdata, 32'hCAFEF00D);

    // Contention between I and D refills over four requests, from a fresh reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    d_left = 2;
    i_left = 2;
    irom_read_ce   = 1'b1;
    irom_addr      = 30'h1000;
    dram_read_ce   = 1'b1;
    dram_read_addr = 30'h2000;
    for (int r = 0; r < 4; r++) begin
      wait_req();
      ack_after(1, 32'hA0000000 + r);
      finish_fin(k);
      grants[r] = k;
      if (k == 1) i_left--;
      if (k == 2) d_left--;
      tick();
      if (k == 1 && i_left > 0) begin irom_read_ce = 1'b1; irom_addr = irom_addr + 1; end
      if (k == 2 && d_left > 0) begin dram_read_ce = 1'b1; dram_read_addr = dram_read_addr + 1; end
    end
    if (RR) exp_seq = '{2, 1, 2, 1};
    else    exp_seq = '{2, 2, 1, 1};
    for (int r = 0; r < 4; r++) chk($sformatf("grant_seq[%0d]", r), grants[r], exp_seq[r]);
    tick();

    // Reset during a transfer, late ack, then a normal refill
    irom_read_ce = 1'b1;
    irom_addr    = 30'h2A0;
    wait_req();
    tick();
    rst          = 1'b0;
    irom_read_ce = 1'b0;
    #1;
    chk("abort_bus_req", {31'b0, bus_req}, 32'd0);
    chk("abort_busy", {31'b0, arb_busy}, 32'd0);
    chk("abort_rom", rom_inst, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    bus_ack   = 1'b1;
    bus_rdata = 32'h22222222;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'hFFFF_FFFF;
    chk("late_ack_fins", {29'b0, dram_write_fin, dram_read_fin, irom_fin}, 32'd0);
    chk("late_ack_rom", rom_inst, 32'd0);
    irom_read_ce = 1'b1;
    irom_addr    = 30'h300;
    wait_req();
    chk("post_addr", {2'b0, bus_addr}, 32'h300);
    ack_after(1, 32'hA5A5A5A5);
    chk("post_fin", {31'b0, irom_fin}, 32'd1);
    chk("post_rom", rom_inst, 32'hA5A5A5A5);
    finish_fin(k);
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
